// File: rtl/lynxTypes.sv
// Shared types for the DMA ISR request pipeline: payload width, packed request
// layout and the skid-buffer state encoding.
package lynxTypes;

    localparam int DMA_ISR_REQ_BITS = 32;

    typedef struct packed {
        logic [3:0]  vfid;
        logic [5:0]  pid;
        logic        host;
        logic        last;
        logic [19:0] len;
    } dma_isr_req_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Number of entries a stage holds in a given state.
    function automatic logic [1:0] occ_of(input skid_state_e st);
        logic [1:0] n;
        case (st)
            ST_EMPTY: n = 2'd0;
            ST_HALF:  n = 2'd1;
            ST_FULL:  n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dma_isr_skid_stage.sv
// Single-channel, single-stage skid buffer. Every output (ready, valid, data,
// occupancy) comes straight from a flop, so no combinational path crosses it.
module dma_isr_skid_stage
    import lynxTypes::*;
#(
    parameter int DATA_BITS = DMA_ISR_REQ_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DATA_BITS-1:0] s_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_BITS-1:0] m_data_o,
    output logic [1:0]           occupancy
);

    skid_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] main_q, skid_q;
    logic                 s_ready_q, m_valid_q;
    logic [1:0]           occ_q;
    logic                 in_xfer_s, out_xfer_s;

    assign in_xfer_s  = s_valid_i & s_ready_q;
    assign out_xfer_s = m_valid_q & m_ready_i;

    // Next-state decision; flush overrides whatever the handshakes asked for.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) state_d = ST_HALF;
                else           state_d = ST_EMPTY;
            end
            ST_HALF: begin
                if (in_xfer_s && !out_xfer_s)      state_d = ST_FULL;
                else if (out_xfer_s && !in_xfer_s) state_d = ST_EMPTY;
                else                               state_d = ST_HALF;
            end
            ST_FULL: begin
                if (out_xfer_s) state_d = ST_HALF;
                else            state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
        else       state_d = state_d;
    end

    // State, handshake flags and payload registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            occ_q     <= 2'd0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != ST_FULL);
            m_valid_q <= (state_d != ST_EMPTY);
            occ_q     <= occ_of(state_d);
            case (state_q)
                ST_EMPTY: if (in_xfer_s) main_q <= s_data_i;
                ST_HALF: begin
                    if (in_xfer_s && out_xfer_s) main_q <= s_data_i;
                    else if (in_xfer_s)          skid_q <= s_data_i;
                end
                ST_FULL: if (out_xfer_s) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = main_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/dma_isr_pipe_mc.sv
// N_CH independent channels, each a chain of N_STAGES skid stages.
// Optional per-channel output transfer counters: DMA_ISR_PIPE_STATS_EN.
module dma_isr_pipe_mc
    import lynxTypes::*;
#(
    parameter int  N_CH      = 4,
    parameter int  N_STAGES  = 2,
    parameter int  DATA_BITS = DMA_ISR_REQ_BITS,
    // Kept at least 1 bit wide so the pass-through build still has a legal port.
    localparam int OCC_BITS  = (N_STAGES == 0) ? 1 : $clog2(2 * N_STAGES + 1)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      flush,
    input  logic [N_CH-1:0]           s_req_valid,
    output logic [N_CH-1:0]           s_req_ready,
    input  logic [N_CH*DATA_BITS-1:0] s_req_data,
    output logic [N_CH-1:0]           m_req_valid,
    input  logic [N_CH-1:0]           m_req_ready,
    output logic [N_CH*DATA_BITS-1:0] m_req_data,
    output logic [N_CH*OCC_BITS-1:0]  occ
`ifdef DMA_ISR_PIPE_STATS_EN
    ,
    output logic [N_CH*32-1:0]        xfer_cnt
`endif
);

    if (N_STAGES == 0) begin : g_bypass
        assign s_req_ready = m_req_ready;
        assign m_req_valid = s_req_valid;
        assign m_req_data  = s_req_data;
        assign occ         = '0;
    end else begin : g_pipe
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic [N_STAGES:0]    vld_s, rdy_s;
            logic [DATA_BITS-1:0] dat_s [N_STAGES+1];
            logic [1:0]           stage_occ_s [N_STAGES];
            logic [OCC_BITS-1:0]  sum_s;

            assign vld_s[0]        = s_req_valid[c];
            assign dat_s[0]        = s_req_data[c*DATA_BITS +: DATA_BITS];
            assign s_req_ready[c]  = rdy_s[0];
            assign m_req_valid[c]  = vld_s[N_STAGES];
            assign rdy_s[N_STAGES] = m_req_ready[c];
            assign m_req_data[c*DATA_BITS +: DATA_BITS] = dat_s[N_STAGES];

            for (genvar s = 0; s < N_STAGES; s++) begin : g_st
                dma_isr_skid_stage #(
                    .DATA_BITS (DATA_BITS)
                ) u_stage (
                    .clk_i     (aclk),
                    .rst_i     (areset),
                    .flush     (flush),
                    .s_valid_i (vld_s[s]),
                    .s_ready_o (rdy_s[s]),
                    .s_data_i  (dat_s[s]),
                    .m_valid_o (vld_s[s+1]),
                    .m_ready_i (rdy_s[s+1]),
                    .m_data_o  (dat_s[s+1]),
                    .occupancy (stage_occ_s[s])
                );
            end

            // Channel occupancy is the sum of its stages' entry counts.
            always_comb begin
                sum_s = '0;
                for (int s = 0; s < N_STAGES; s++) begin
                    sum_s = sum_s + OCC_BITS'(stage_occ_s[s]);
                end
            end

            assign occ[c*OCC_BITS +: OCC_BITS] = sum_s;
        end
    end

`ifdef DMA_ISR_PIPE_STATS_EN
    for (genvar c = 0; c < N_CH; c++) begin : g_cnt
        logic [31:0] cnt_q;

        // Saturating count of m-side transfers; flush deliberately leaves it alone.
        always_ff @(posedge aclk) begin
            if (areset) begin
                cnt_q <= 32'd0;
            end else if (m_req_valid[c] && m_req_ready[c] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end else begin
                cnt_q <= cnt_q;
            end
        end

        assign xfer_cnt[c*32 +: 32] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_dma_isr_pipe_mc.sv
// Scoreboard bench for dma_isr_pipe_mc: per-channel FIFO reference model plus
// directed scenarios and a randomized phase. Stats checks need DMA_ISR_PIPE_STATS_EN.
module tb_dma_isr_pipe_mc;

    localparam int N_CH = 4;
    localparam int N_STAGES = 2;
    localparam int DW = 32;
    localparam int OB = 3;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 flush;
    logic [N_CH-1:0]      s_req_valid;
    logic [N_CH-1:0]      s_req_ready;
    logic [N_CH*DW-1:0]   s_req_data;
    logic [N_CH-1:0]      m_req_valid;
    logic [N_CH-1:0]      m_req_ready;
    logic [N_CH*DW-1:0]   m_req_data;
    logic [N_CH*OB-1:0]   occ;
`ifdef DMA_ISR_PIPE_STATS_EN
    logic [N_CH*32-1:0]   xfer_cnt;
`endif

    always #5 aclk = ~aclk;

    dma_isr_pipe_mc #(
        .N_CH      (N_CH),
        .N_STAGES  (N_STAGES),
        .DATA_BITS (DW)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .flush       (flush),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .occ         (occ)
`ifdef DMA_ISR_PIPE_STATS_EN
        ,
        .xfer_cnt    (xfer_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    // Reference model: each channel is an ordered FIFO of accepted payloads.
    logic [31:0] exp_q [N_CH][$];
    int  cnt_m [N_CH];
    int  xcnt [N_CH];
    bit  acc [N_CH];
    int  acc_tot [N_CH], out_tot [N_CH], first_in [N_CH], first_out [N_CH], last_out [N_CH], max_occ [N_CH];
    int  cyc = 0;
    int  left [N_CH], seq [N_CH], snk [N_CH];
    bit  src_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < N_CH; c++) begin
            acc_tot[c] = 0; out_tot[c] = 0; first_in[c] = -1;
            first_out[c] = -1; last_out[c] = -1; max_occ[c] = 0;
        end
    endtask

    // Monitor: samples each cycle's handshakes mid-cycle and updates the model.
    always @(negedge aclk) begin
        cyc++;
        for (int c = 0; c < N_CH; c++) begin
            logic inx, outx;
            logic [31:0] od;
            int o;
            inx  = s_req_valid[c] & s_req_ready[c];
            outx = m_req_valid[c] & m_req_ready[c];
            od   = m_req_data[c*DW +: DW];
            o    = int'(occ[c*OB +: OB]);
            if (!areset) begin
                check("occ", 64'(o), 64'(cnt_m[c]));
                if (cnt_m[c] == 0) check("idle_rdy_vld", {62'd0, s_req_ready[c], m_req_valid[c]}, 64'd2);
                if (o > max_occ[c]) max_occ[c] = o;
            end
            if (outx) begin
                if (exp_q[c].size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious ch%0d: got %0h expected none", c, od);
                end else begin
                    check("data", 64'(od), 64'(exp_q[c].pop_front()));
                end
                out_tot[c]++;
                if (first_out[c] < 0) first_out[c] = cyc;
                last_out[c] = cyc;
            end
            if (inx) begin
                acc_tot[c]++;
                if (first_in[c] < 0) first_in[c] = cyc;
            end
            acc[c] = inx;
            if (areset) begin
                exp_q[c].delete(); cnt_m[c] = 0; xcnt[c] = 0;
            end else if (flush) begin
                exp_q[c].delete(); cnt_m[c] = 0;
                if (outx) xcnt[c]++;
            end else begin
                if (inx) exp_q[c].push_back(s_req_data[c*DW +: DW]);
                cnt_m[c] = cnt_m[c] + int'(inx) - int'(outx);
                if (outx) xcnt[c]++;
            end
        end
    end

    // Driver: source holds valid/data until accepted; sink follows snk mode.
    initial begin
        s_req_valid = '0;
        s_req_data  = '0;
        m_req_ready = '0;
        forever begin
            @(posedge aclk); #1;
            for (int c = 0; c < N_CH; c++) begin
                if (acc[c]) begin seq[c]++; left[c]--; end
                if (!(s_req_valid[c] && !acc[c]))
                    s_req_valid[c] = (left[c] > 0) && (!src_rand || ($urandom_range(3, 0) != 0));
                s_req_data[c*DW +: DW] = {4'(c), 28'(seq[c])};
                case (snk[c])
                    0:       m_req_ready[c] = 1'b0;
                    1:       m_req_ready[c] = 1'b1;
                    default: m_req_ready[c] = 1'($urandom_range(1, 0));
                endcase
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge aclk);
            done = (s_req_valid == '0) && (occ == '0);
            for (int c = 0; c < N_CH; c++)
                if (left[c] > 0 || exp_q[c].size() != 0) done = 1'b0;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: got busy expected idle within %0d cycles", budget);
        end
    endtask

    task automatic pulse_reset();
        @(posedge aclk); #2 areset = 1'b1;
        @(posedge aclk); #2 areset = 1'b0;
    endtask

    initial begin
        bit ok;
        areset = 1'b1;
        flush  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            left[c] = 0; seq[c] = 0; snk[c] = 1; cnt_m[c] = 0; xcnt[c] = 0; acc[c] = 1'b0;
        end
        clear_stats();
        repeat (3) @(posedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        check("rst_ready", 64'(s_req_ready), 64'hF);
        check("rst_valid", 64'(m_req_valid), 64'h0);
        check("rst_data",  64'(m_req_data), 64'h0);
        check("rst_occ",   64'(occ), 64'h0);

        // Streaming channel 0: 0x1..0x10 back-to-back.
        clear_stats();
        seq[0] = 1; left[0] = 16;
        wait_idle(100);
        check("stream_latency", 64'(first_out[0] - first_in[0]), 64'd2);
        check("stream_count",   64'(out_tot[0]), 64'd16);
        check("stream_rate",    64'(last_out[0] - first_out[0]), 64'd15);
        check("stream_occ_max", 64'(max_occ[0] <= 2), 64'd1);

        // Backpressure on channel 1 absorbs exactly 2*N_STAGES entries.
        clear_stats();
        snk[1] = 0; seq[1] = 32'h100; left[1] = 8;
        repeat (10) @(negedge aclk);
        check("bp_accepted", 64'(acc_tot[1]), 64'd4);
        check("bp_ready",    64'(s_req_ready[1]), 64'd0);
        check("bp_occ",      64'(occ[1*OB +: OB]), 64'd4);
        snk[1] = 1;
        wait_idle(100);
        check("bp_delivered", 64'(out_tot[1]), 64'd8);

        // Stalled channel 2 must not disturb streaming channel 3.
        clear_stats();
        snk[2] = 0; seq[2] = 32'h200; left[2] = 6;
        snk[3] = 1; seq[3] = 32'h300; left[3] = 20;
        repeat (40) @(negedge aclk);
        check("indep_count3", 64'(out_tot[3]), 64'd20);
        check("indep_rate3",  64'(last_out[3] - first_out[3]), 64'd19);
        check("indep_stall2", 64'(out_tot[2]), 64'd0);
        snk[2] = 1;
        wait_idle(100);

        // Flush at occ=3 with an input transfer in the same cycle.
        clear_stats();
        snk[1] = 0; seq[1] = 32'h400; left[1] = 3;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge aclk);
            ok = (occ[1*OB +: OB] == 3'd3) && (s_req_valid[1] == 1'b0);
        end
        check("flush_pre_occ", 64'(occ[1*OB +: OB]), 64'd3);
        @(posedge aclk); #2;
        left[1] = 0;
        s_req_valid[1] = 1'b1;
        s_req_data[1*DW +: DW] = 32'hDEAD_0001;
        flush = 1'b1;
        @(negedge aclk);
        check("flush_in_ready", 64'(s_req_ready[1]), 64'd1);
        @(posedge aclk); #2 flush = 1'b0;
        @(negedge aclk);
        check("flush_occ",   64'(occ[1*OB +: OB]), 64'd0);
        check("flush_valid", 64'(m_req_valid[1]), 64'd0);
        snk[1] = 1; seq[1] = 32'h500; left[1] = 4;
        wait_idle(100);
        check("flush_after_count", 64'(out_tot[1]), 64'd4);

        // Reset in the middle of buffered traffic.
        for (int c = 0; c < N_CH; c++) begin snk[c] = 0; seq[c] = 32'h600 + c * 32'h10; left[c] = 5; end
        repeat (8) @(negedge aclk);
        pulse_reset();
        for (int c = 0; c < N_CH; c++) left[c] = 0;
        @(negedge aclk);
        check("rst2_ready", 64'(s_req_ready), 64'hF);
        check("rst2_valid", 64'(m_req_valid), 64'h0);
        check("rst2_data",  64'(m_req_data), 64'h0);
        check("rst2_occ",   64'(occ), 64'h0);
        for (int c = 0; c < N_CH; c++) begin snk[c] = 1; left[c] = 3; end
        wait_idle(100);

        // Randomized valid/ready on every channel from a clean reset.
        pulse_reset();
        clear_stats();
        src_rand = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            snk[c] = 2; seq[c] = 32'h1000; left[c] = (c == 0) ? 1000 : 300;
        end
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge aclk);
            ok = 1'b1;
            for (int c = 0; c < N_CH; c++) if (left[c] > 0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL random_timeout: got sources busy expected done");
        end
        src_rand = 1'b0;
        for (int c = 0; c < N_CH; c++) snk[c] = 1;
        wait_idle(200);
        check("rand_count0", 64'(out_tot[0]), 64'd1000);

`ifdef DMA_ISR_PIPE_STATS_EN
        check("stats_ch0", 64'(xfer_cnt[31:0]), 64'd1000);
        for (int c = 0; c < N_CH; c++) check("stats_model", 64'(xfer_cnt[c*32 +: 32]), 64'(xcnt[c]));
        @(posedge aclk); #2 flush = 1'b1;
        @(posedge aclk); #2 flush = 1'b0;
        @(negedge aclk);
        check("stats_flush", 64'(xfer_cnt[31:0]), 64'd1000);
        pulse_reset();
        @(negedge aclk);
        check("stats_reset", 64'(xfer_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
